// File: rtl/safelock_controller.sv
// Safelock code-path sequencer: collects BCD digits, checks them against the stored code,
// times the unlock window, counts failures, enforces lockout and reprograms the code.
module safelock_controller #(
    parameter logic [11:0] DEFAULT_CODE   = 12'h123,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 500,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_digit_valid,
    input  logic [3:0]  i_digit,
    input  logic        i_enter,
    input  logic        i_clear,
    input  logic        i_set_mode,
    output logic        o_dec_en,
    output logic [11:0] o_password,
    output logic        o_unlocked,
    output logic        o_lockout,
    output logic [1:0]  o_fail_cnt,
    output logic        o_err
);

    localparam int unsigned UW = $clog2(UNLOCK_CYCLES) + 1;
    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        StIdle, StEntry, StCheck, StUnlocked, StProgram, StCommit, StLockout
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     entry_q, entry_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [1:0]      fail_q, fail_d;
    logic [11:0]     code_q, code_d;
    logic [UW-1:0]   utmr_q, utmr_d;
    logic [LW-1:0]   ltmr_q, ltmr_d;
    logic            err_q, err_d;
    logic            dec_en_q, unlocked_q, lockout_q;
    logic            digit_ok;
    logic [1:0]      fail_next;

    assign digit_ok  = (i_digit <= 4'd9);
    assign fail_next = fail_q + 2'd1;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        code_d  = code_q;
        utmr_d  = utmr_q;
        ltmr_d  = ltmr_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // clear/enter have no effect here but still mask a same-cycle digit
                if (!i_clear && !i_enter && i_digit_valid) begin
                    if (digit_ok) begin
                        entry_d = {entry_q[7:0], i_digit};
                        cnt_d   = cnt_q + 2'd1;
                        state_d = StEntry;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StEntry, StProgram: begin
                if (i_clear) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = (state_q == StEntry) ? StIdle : StUnlocked;
                end else if (i_enter) begin
                    if (cnt_q == 2'd3) state_d = (state_q == StEntry) ? StCheck : StCommit;
                    else               err_d   = 1'b1;
                end else if (i_digit_valid) begin
                    if (digit_ok && cnt_q != 2'd3) begin
                        entry_d = {entry_q[7:0], i_digit};
                        cnt_d   = cnt_q + 2'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StCheck: begin
                if (entry_q == code_q) begin
                    fail_d  = '0;
                    utmr_d  = UW'(UNLOCK_CYCLES - 1);
                    state_d = StUnlocked;
                end else begin
                    fail_d  = fail_next;
                    entry_d = '0;
                    cnt_d   = '0;
                    if (fail_next == 2'(MAX_TRIES)) begin
                        ltmr_d  = LW'(LOCKOUT_CYCLES - 1);
                        state_d = StLockout;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StUnlocked: begin
                if (i_clear || utmr_q == '0) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    utmr_d = utmr_q - UW'(1);
                    if (i_set_mode) begin
                        entry_d = '0;
                        cnt_d   = '0;
                        state_d = StProgram;
                    end
                end
            end
            StCommit: begin
                code_d  = entry_q;
                utmr_d  = UW'(UNLOCK_CYCLES - 1);
                state_d = StUnlocked;
            end
            StLockout: begin
                if (ltmr_q == '0) begin
                    fail_d  = '0;
                    state_d = StIdle;
                end else begin
                    ltmr_d = ltmr_q - LW'(1);
                end
            end
            default: begin
                entry_d = '0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output flags are decoded from the next state so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            entry_q    <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            code_q     <= DEFAULT_CODE;
            utmr_q     <= '0;
            ltmr_q     <= '0;
            err_q      <= 1'b0;
            dec_en_q   <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            code_q     <= code_d;
            utmr_q     <= utmr_d;
            ltmr_q     <= ltmr_d;
            err_q      <= err_d;
            dec_en_q   <= (state_d == StEntry) || (state_d == StCheck) ||
                          (state_d == StProgram) || (state_d == StCommit);
            unlocked_q <= (state_d == StUnlocked) || (state_d == StProgram) ||
                          (state_d == StCommit);
            lockout_q  <= (state_d == StLockout);
        end
    end

    assign o_dec_en   = dec_en_q;
    assign o_password = entry_q;
    assign o_unlocked = unlocked_q;
    assign o_lockout  = lockout_q;
    assign o_fail_cnt = fail_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_safelock_controller.sv
// Directed bench for safelock_controller: each step queues its expected output vector,
// then pops and compares it one edge later.
module tb_safelock_controller;

    localparam int unsigned UNLOCK = 10;
    localparam int unsigned LOCK   = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0, en = 1'b0, clr = 1'b0, sm = 1'b0;
    logic [3:0]  d = 4'd0;
    logic        dec_en, unlocked, lockout, err;
    logic [11:0] password;
    logic [1:0]  fail_cnt;

    always #5 clk = ~clk;

    safelock_controller #(
        .DEFAULT_CODE   (12'h123),
        .MAX_TRIES      (3),
        .UNLOCK_CYCLES  (UNLOCK),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_digit_valid (dv),
        .i_digit       (d),
        .i_enter       (en),
        .i_clear       (clr),
        .i_set_mode    (sm),
        .o_dec_en      (dec_en),
        .o_password    (password),
        .o_unlocked    (unlocked),
        .o_lockout     (lockout),
        .o_fail_cnt    (fail_cnt),
        .o_err         (err)
    );

    typedef struct {
        string       tag;
        logic [17:0] exp;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    // {dec_en, password, unlocked, lockout, fail_cnt, err}
    function automatic logic [17:0] ev(input logic de, input logic [11:0] pw, input logic un,
                                       input logic lo, input logic [1:0] fc, input logic er);
        return {de, pw, un, lo, fc, er};
    endfunction

    task automatic cyc(input logic v, input logic [3:0] dg, input logic e, input logic c,
                       input logic s, input logic [17:0] exp, input string tag);
        item_t       it;
        logic [17:0] obs;
        dv = v; d = dg; en = e; clr = c; sm = s;
        sb.push_back('{tag, exp});
        @(posedge clk);
        #1;
        dv = 1'b0; d = 4'd0; en = 1'b0; clr = 1'b0; sm = 1'b0;
        it  = sb.pop_front();
        obs = {dec_en, password, unlocked, lockout, fail_cnt, err};
        checks++;
        assert (obs === it.exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
        end
    endtask

    task automatic idle(input logic [17:0] exp, input string tag);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, exp, tag);
    endtask

    task automatic dig(input logic [3:0] dg, input logic [17:0] exp, input string tag);
        cyc(1'b1, dg, 1'b0, 1'b0, 1'b0, exp, tag);
    endtask

    task automatic enter(input logic [17:0] exp, input string tag);
        cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, exp, tag);
    endtask

    // Enters 4,5,6 from IDLE with 'prior' failures already recorded.
    task automatic wrong_attempt(input logic [1:0] prior);
        dig(4'd4, ev(1, 12'h004, 0, 0, prior, 0), "wrong_d1");
        dig(4'd5, ev(1, 12'h045, 0, 0, prior, 0), "wrong_d2");
        dig(4'd6, ev(1, 12'h456, 0, 0, prior, 0), "wrong_d3");
        enter(ev(1, 12'h456, 0, 0, prior, 0), "wrong_enter");
        if (prior == 2'd2) idle(ev(0, 12'h000, 0, 1, 2'd3, 0), "lockout_entry");
        else               idle(ev(0, 12'h000, 0, 0, prior + 2'd1, 0), "fail_step");
    endtask

    task automatic unlock_with(input logic [11:0] code, input logic [1:0] prior);
        dig(code[11:8], ev(1, {8'h00, code[11:8]}, 0, 0, prior, 0), "code_d1");
        dig(code[7:4],  ev(1, {4'h0, code[11:4]}, 0, 0, prior, 0), "code_d2");
        dig(code[3:0],  ev(1, code, 0, 0, prior, 0), "code_d3");
        enter(ev(1, code, 0, 0, prior, 0), "code_enter");
        idle(ev(0, code, 1, 0, 2'd0, 0), "unlock");
    endtask

    initial begin
        // Reset
        idle(ev(0, 12'h000, 0, 0, 2'd0, 0), "reset");
        idle(ev(0, 12'h000, 0, 0, 2'd0, 0), "reset_hold");
        rst_n = 1'b1;

        // 1. Correct code, auto-relock after UNLOCK cycles
        unlock_with(12'h123, 2'd0);
        for (int i = 0; i < UNLOCK - 1; i++) idle(ev(0, 12'h123, 1, 0, 2'd0, 0), "unlock_hold");
        idle(ev(0, 12'h000, 0, 0, 2'd0, 0), "auto_relock");

        // 2. Lockout after three failures; inputs ignored while locked out
        wrong_attempt(2'd0);
        wrong_attempt(2'd1);
        wrong_attempt(2'd2);
        for (int i = 0; i < LOCK - 1; i++) begin
            if (i % 3 == 0)      dig(4'hA, ev(0, 12'h000, 0, 1, 2'd3, 0), "lockout_bad_digit");
            else if (i % 3 == 1) dig(4'd1, ev(0, 12'h000, 0, 1, 2'd3, 0), "lockout_digit");
            else                 enter(ev(0, 12'h000, 0, 1, 2'd3, 0), "lockout_enter");
        end
        idle(ev(0, 12'h000, 0, 0, 2'd0, 0), "lockout_exit");

        // 3. Reprogram to 987
        unlock_with(12'h123, 2'd0);
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, ev(1, 12'h000, 1, 0, 2'd0, 0), "set_mode");
        dig(4'd9, ev(1, 12'h009, 1, 0, 2'd0, 0), "prog_d1");
        dig(4'd8, ev(1, 12'h098, 1, 0, 2'd0, 0), "prog_d2");
        dig(4'd7, ev(1, 12'h987, 1, 0, 2'd0, 0), "prog_d3");
        enter(ev(1, 12'h987, 1, 0, 2'd0, 0), "prog_commit");
        for (int i = 0; i < UNLOCK; i++) idle(ev(0, 12'h987, 1, 0, 2'd0, 0), "prog_hold");
        idle(ev(0, 12'h000, 0, 0, 2'd0, 0), "prog_relock");
        dig(4'd1, ev(1, 12'h001, 0, 0, 2'd0, 0), "old_d1");
        dig(4'd2, ev(1, 12'h012, 0, 0, 2'd0, 0), "old_d2");
        dig(4'd3, ev(1, 12'h123, 0, 0, 2'd0, 0), "old_d3");
        enter(ev(1, 12'h123, 0, 0, 2'd0, 0), "old_enter");
        idle(ev(0, 12'h000, 0, 0, 2'd1, 0), "old_code_fails");
        unlock_with(12'h987, 2'd1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, ev(0, 12'h000, 0, 0, 2'd0, 0), "manual_relock");

        // 4. Rejections
        dig(4'hA, ev(0, 12'h000, 0, 0, 2'd0, 1), "bad_digit_err");
        idle(ev(0, 12'h000, 0, 0, 2'd0, 0), "bad_digit_clear");
        dig(4'd1, ev(1, 12'h001, 0, 0, 2'd0, 0), "rej_d1");
        dig(4'd2, ev(1, 12'h012, 0, 0, 2'd0, 0), "rej_d2");
        dig(4'd3, ev(1, 12'h123, 0, 0, 2'd0, 0), "rej_d3");
        dig(4'd4, ev(1, 12'h123, 0, 0, 2'd0, 1), "fourth_digit_err");
        idle(ev(1, 12'h123, 0, 0, 2'd0, 0), "fourth_digit_clear");
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, ev(0, 12'h000, 0, 0, 2'd0, 0), "clear");
        dig(4'd1, ev(1, 12'h001, 0, 0, 2'd0, 0), "short_d1");
        dig(4'd2, ev(1, 12'h012, 0, 0, 2'd0, 0), "short_d2");
        enter(ev(1, 12'h012, 0, 0, 2'd0, 1), "short_enter_err");
        idle(ev(1, 12'h012, 0, 0, 2'd0, 0), "short_enter_clear");

        // 5. Priority: clear beats enter and digit with a full buffer
        dig(4'd3, ev(1, 12'h123, 0, 0, 2'd0, 0), "prio_d3");
        cyc(1'b1, 4'd5, 1'b1, 1'b1, 1'b0, ev(0, 12'h000, 0, 0, 2'd0, 0), "prio_clear");
        idle(ev(0, 12'h000, 0, 0, 2'd0, 0), "prio_no_attempt");

        // 6. Reset mid-lockout restores the default code
        wrong_attempt(2'd0);
        wrong_attempt(2'd1);
        wrong_attempt(2'd2);
        idle(ev(0, 12'h000, 0, 1, 2'd3, 0), "lockout_again");
        rst_n = 1'b0;
        idle(ev(0, 12'h000, 0, 0, 2'd0, 0), "reset_mid_lockout");
        rst_n = 1'b1;
        unlock_with(12'h123, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/safelock_controller.md
# safelock_controller

Sequencing controller for the safelock's 3-digit code path. It collects keypad digits into a 12-bit BCD entry buffer and drives the `password_decoder` enable and password inputs so the entry is shown on the three 7-segment digits. It compares the entry against a stored code, grants unlock for a bounded time, counts failures, enforces lockout, and lets the stored code be reprogrammed while unlocked.

## Interface
Parameters:
- `DEFAULT_CODE`, 12'h123, stored code after reset (3 BCD digits, MS digit in [11:8]).
- `MAX_TRIES`, 3, consecutive failures that trigger lockout (1..3).
- `UNLOCK_CYCLES`, 500, cycles the `UNLOCKED` state is held before auto-relock.
- `LOCKOUT_CYCLES`, 1000, cycles input is ignored after `MAX_TRIES` failures.

Ports:
- `i_clk` in 1: single clock; all logic on the rising edge.
- `i_rst_n` in 1: reset, synchronous and active-low.
- `i_digit_valid` in 1: one-cycle strobe qualifying `i_digit`.
- `i_digit` in 4: keypad digit; legal values 0..9.
- `i_enter` in 1: one-cycle strobe to submit the entry.
- `i_clear` in 1: one-cycle strobe to discard the entry.
- `i_set_mode` in 1: one-cycle strobe requesting code programming (honoured only in `UNLOCKED`).
- `o_dec_en` out 1: connects to `password_decoder` `i_en`.
- `o_password` out 12: connects to `password_decoder` `i_password`.
- `o_unlocked` out 1: lock released.
- `o_lockout` out 1: lockout active.
- `o_fail_cnt` out 2: current consecutive failure count.
- `o_err` out 1: one-cycle pulse flagging a rejected input.

## Operation
- States: `IDLE`, `ENTRY`, `CHECK`, `UNLOCKED`, `PROGRAM`, `PCOMMIT`, `LOCKOUT`.
- Entry buffer `buf[11:0]` and digit count `cnt` (0..3).
  - Accepted digit: `buf <= {buf[7:0], i_digit}`, `cnt <= cnt + 1`.
- A digit is rejected, with an `o_err` pulse and no state change, when:
  - `i_digit > 9`, or
  - `cnt == 3` (buffer full).
- Same-cycle priority: `i_clear` > `i_enter` > `i_digit_valid`. Lower-priority strobes in that cycle are dropped silently.
- `IDLE`:
  - `buf = 0`, `cnt = 0`, `o_dec_en = 0`.
  - An accepted digit loads `buf` and moves to `ENTRY`.
  - `i_enter` and `i_clear` are ignored.
- `ENTRY`:
  - `o_dec_en = 1`.
  - `i_clear` → `IDLE`.
  - `i_enter` with `cnt < 3` → `o_err` pulse, stay in `ENTRY`, no attempt counted.
  - `i_enter` with `cnt == 3` → `CHECK`.
- `CHECK` (one cycle):
  - `buf == code` → `UNLOCKED`; `fail_cnt <= 0`; unlock timer loaded.
  - Otherwise `fail_cnt <= fail_cnt + 1`.
    - If the new value equals `MAX_TRIES` → `LOCKOUT`.
    - Else → `IDLE`.
- `UNLOCKED`:
  - `o_unlocked = 1`, `o_dec_en = 0`; digits are ignored.
  - The timer counts down. On expiry → `IDLE`.
  - `i_set_mode` → `PROGRAM`, clearing `buf`/`cnt`.
  - `i_clear` → `IDLE` (manual relock).
- `PROGRAM`:
  - `o_unlocked = 1`, `o_dec_en = 1`; digit entry works as in `ENTRY`.
  - The timer is frozen.
  - `i_enter` with `cnt == 3` → `PCOMMIT`.
  - `i_enter` with `cnt < 3` → `o_err` pulse.
  - `i_clear` → `UNLOCKED` with the code unchanged.
- `PCOMMIT` (one cycle): `code <= buf`; timer reloaded; → `UNLOCKED`.
- `LOCKOUT`:
  - `o_lockout = 1`, `o_dec_en = 0`.
  - All inputs are ignored and `o_err` is never asserted.
  - After `LOCKOUT_CYCLES` → `IDLE` with `fail_cnt <= 0`.
- Fixed output relationships:
  - `o_password = buf` in every state.
  - `o_fail_cnt = fail_cnt`.
- Counters are sized by `$clog2` of their parameter + 1. The timer is a down-counter whose terminal count is 0.

## Timing
- Reset values (`i_rst_n` low at a clock edge):
  - State `IDLE`, `buf = 0`, `cnt = 0`, `fail_cnt = 0`, `code = DEFAULT_CODE`.
  - `o_dec_en = 0`, `o_password = 0`, `o_unlocked = 0`, `o_lockout = 0`, `o_fail_cnt = 0`, `o_err = 0`.
- Reset taken mid-operation (any state, including `LOCKOUT` or `PROGRAM`) returns everything to the reset values at the next edge.
- All outputs are registered.
- Latencies:
  - Digit accepted at edge N → `o_password` updated after edge N; `o_dec_en` = 1 after N when leaving `IDLE`.
  - `i_enter` at edge N → `CHECK` during N+1 → `o_unlocked` or `o_lockout` high after edge N+1.
  - `o_err` is high for exactly the one cycle following the offending strobe.
- `UNLOCKED` lasts exactly `UNLOCK_CYCLES` cycles absent other input. `LOCKOUT` lasts exactly `LOCKOUT_CYCLES` cycles.

## Test plan
Bench parameters: `UNLOCK_CYCLES = 10`, `LOCKOUT_CYCLES = 20`.
1. Correct code: reset, enter digits 1, 2, 3, then `i_enter` → `o_password = 12'h123`, `o_dec_en = 1` during entry; `o_unlocked = 1` two cycles after enter; it falls after 10 cycles with `o_password = 0`.
2. Lockout: three wrong entries of 4, 5, 6 → `o_fail_cnt` steps 1, 2, then `o_lockout = 1` for 20 cycles. Digits and enter pressed during lockout are ignored with no `o_err`. Afterwards `o_fail_cnt = 0`.
3. Reprogram: unlock with 123, then `i_set_mode`, digits 9, 8, 7, `i_enter` → relocks after 10 cycles. Code 123 now fails (`o_fail_cnt = 1`) and code 987 unlocks.
4. Rejections: each of the following gives a single-cycle `o_err` and leaves `buf` unchanged:
   - digit 4'hA;
   - a fourth digit after 1, 2, 3;
   - `i_enter` after only 2 digits.
5. Priority: `i_clear` + `i_enter` + digit all asserted in the same cycle with `cnt = 3` → `IDLE`, `buf = 0`, no attempt counted.
6. Reset mid-lockout: assert `i_rst_n = 0` for one edge → all outputs return to their reset values at that edge, and `code` returns to `12'h123`.
